// File: rtl/axil_wr_sequencer_pkg.sv
// axil_seq_pkg: shared FSM state, AXI response codes and command record for the write sequencer.
package axil_seq_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } cmd_t;
endpackage

// File: rtl/axil_wr_sequencer_if.sv
// axil_wr_sequencer_if: command intake, master request, B-channel taps and status of the write sequencer.
interface axil_wr_sequencer_if;
  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [31:0] s_cmd_addr;
  logic [31:0] s_cmd_data;
  logic [3:0]  s_cmd_strb;
  logic        o_wr;
  logic [31:0] o_addrin;
  logic [31:0] o_din;
  logic [3:0]  o_strb;
  logic        i_bvalid;
  logic        i_bready;
  logic [1:0]  i_bresp;
  logic        o_done;
  logic [1:0]  o_resp;
  logic        o_busy;
  logic [7:0]  o_err_cnt;
  logic        o_timeout;
  modport slave (
    input  s_cmd_valid, s_cmd_addr, s_cmd_data, s_cmd_strb, i_bvalid, i_bready, i_bresp,
    output s_cmd_ready, o_wr, o_addrin, o_din, o_strb, o_done, o_resp, o_busy, o_err_cnt, o_timeout
  );
  modport master (
    output s_cmd_valid, s_cmd_addr, s_cmd_data, s_cmd_strb, i_bvalid, i_bready, i_bresp,
    input  s_cmd_ready, o_wr, o_addrin, o_din, o_strb, o_done, o_resp, o_busy, o_err_cnt, o_timeout
  );
endinterface

// File: rtl/axil_wr_sequencer_fifo.sv
// axil_cmd_fifo: synchronous command FIFO with full/empty flags; head is visible on dout.
module axil_cmd_fifo
  import axil_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  cmd_t din,
  output cmd_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  cmd_t mem [DEPTH];
  logic [AW:0] wp, rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (push && !full) mem[wp[AW-1:0]] <= din;
  assign dout = mem[rp[AW-1:0]];
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

// File: rtl/axil_wr_sequencer.sv
// axil_wr_sequencer: queues write commands and hands them one at a time to an AXI-Lite write master.
// Defining AXIL_SEQ_TIMEOUT_EN adds a B-response watchdog of TIMEOUT_CYCLES cycles.
module axil_wr_sequencer
  import axil_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic i_clk,
  input logic i_resetn,
  axil_wr_sequencer_if.slave bus
);
  state_t state, state_n;
  cmd_t cmd_in, head;
  logic full, empty, push, hs, to_hit, pop, done_q, timeout_q;
  logic [1:0] resp_q;
  logic [7:0] err_q;
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("axil_wr_sequencer: illegal DEPTH or TIMEOUT_CYCLES");
  end
  assign cmd_in = '{addr: bus.s_cmd_addr, data: bus.s_cmd_data, strb: bus.s_cmd_strb};
  assign push = bus.s_cmd_valid && !full;
  assign hs = (state == WAIT_RESP) && bus.i_bvalid && bus.i_bready;
`ifdef AXIL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) to_cnt <= '0;
    else to_cnt <= (state == WAIT_RESP) ? to_cnt + 1'b1 : '0;
  // a handshake in the final watchdog cycle still wins
  assign to_hit = (state == WAIT_RESP) && !hs && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif
  assign pop = hs || to_hit;
  axil_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(i_clk), .rst_n(i_resetn), .push(push), .pop(pop),
    .din(cmd_in), .dout(head), .full(full), .empty(empty)
  );
  // completion always lands in IDLE, which guarantees a gap before the next ISSUE
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? ((empty && !push) ? IDLE : ISSUE) :
              (state == ISSUE) ? WAIT_RESP :
              (state == WAIT_RESP && !pop) ? WAIT_RESP : IDLE;
  end
  always_ff @(posedge i_clk or negedge i_resetn)
    if (!i_resetn) begin
      state <= IDLE;
      done_q <= 1'b0;
      timeout_q <= 1'b0;
      resp_q <= OKAY;
      err_q <= '0;
    end else begin
      state <= state_n;
      done_q <= pop;
      timeout_q <= to_hit;
      if (pop) resp_q <= to_hit ? SLVERR : bus.i_bresp;
      if (pop && (to_hit || bus.i_bresp != OKAY) && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  assign bus.s_cmd_ready = !full;
  assign bus.o_wr = state == ISSUE;
  assign bus.o_addrin = (state != IDLE) ? head.addr : '0;
  assign bus.o_din = (state != IDLE) ? head.data : '0;
  assign bus.o_strb = (state != IDLE) ? head.strb : '0;
  assign bus.o_done = done_q;
  assign bus.o_timeout = timeout_q;
  assign bus.o_resp = resp_q;
  assign bus.o_err_cnt = err_q;
  assign bus.o_busy = !empty || state != IDLE;
endmodule

// File: doc/axil_wr_sequencer.md
AXIL_WR_SEQUENCER -- requirements
Module: axil_wr_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO entries; SHALL be a power of two, 2 to 16.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, response watchdog limit in clock cycles; used only when AXIL_SEQ_TIMEOUT_EN is defined.
REQ-003 i_clk  input  1  the single clock; all logic on its rising edge.
REQ-004 i_resetn  input  1  reset, asynchronous and active-low.
REQ-005 s_cmd_valid  input  1  upstream write command valid.
REQ-006 s_cmd_ready  output  1  sequencer can accept a command.
REQ-007 s_cmd_addr  input  32  write address.
REQ-008 s_cmd_data  input  32  write data.
REQ-009 s_cmd_strb  input  4  byte strobes.
REQ-010 o_wr  output  1  write request to the AXI-Lite write master.
REQ-011 o_addrin / o_din / o_strb  output  32/32/4  command fields presented to the master.
REQ-012 i_bvalid / i_bready  input  1/1  B-channel monitor taps between master and slave.
REQ-013 i_bresp  input  2  B-channel response tap.
REQ-014 o_done  output  1  one-cycle completion pulse.
REQ-015 o_resp  output  2  response of the last completed command.
REQ-016 o_busy  output  1  FIFO non-empty or FSM not IDLE.
REQ-017 o_err_cnt  output  8  count of non-OKAY completions.
REQ-018 o_timeout  output  1  one-cycle watchdog abort pulse; tied 0 without the macro.

Function
REQ-019 Push SHALL occur when s_cmd_valid && s_cmd_ready; s_cmd_ready = !full, with no bypass of a same-cycle pop.
REQ-020 FSM states SHALL be IDLE, ISSUE, WAIT_RESP.
REQ-021 IDLE -> ISSUE SHALL occur when the FIFO is non-empty; a push into an empty FIFO SHALL reach ISSUE on the next cycle.
REQ-022 In ISSUE, o_wr SHALL be high for exactly one cycle with the FIFO head on o_addrin/o_din/o_strb, then the FSM SHALL go to WAIT_RESP.
REQ-023 o_addrin/o_din/o_strb SHALL hold the head values stable from ISSUE until completion.
REQ-024 In WAIT_RESP, i_bvalid && i_bready SHALL trigger completion: pop head, register i_bresp into o_resp, pulse o_done next cycle, go to IDLE.
REQ-025 Back-to-back commands SHALL have at least one IDLE cycle between completion and the next ISSUE.
REQ-026 B handshakes outside WAIT_RESP SHALL be ignored.
REQ-027 o_err_cnt SHALL increment on each completion with o_resp != 2'b00 and saturate at 255.
REQ-028 Simultaneous push and completion-pop SHALL both take effect; occupancy stays unchanged.

Reset
REQ-029 On i_resetn low: FIFO empty, FSM IDLE, o_wr=0, o_done=0, o_timeout=0, o_resp=0, o_err_cnt=0, data outputs 0, s_cmd_ready=1 after release.
REQ-030 Reset mid-transaction SHALL discard all queued and in-flight commands with no o_done.

Configuration
REQ-031 Macro AXIL_SEQ_TIMEOUT_EN defined: a counter runs in WAIT_RESP and at TIMEOUT_CYCLES without a handshake SHALL pop the head, set o_resp=2'b10, pulse o_timeout and o_done, count an error, and go to IDLE.
REQ-032 Macro AXIL_SEQ_TIMEOUT_EN undefined: no counter, WAIT_RESP waits indefinitely, o_timeout=0.

Structure
REQ-033 Package axil_seq_pkg SHALL hold the state enum, the response codes OKAY/EXOKAY/SLVERR/DECERR, and the command struct {addr, data, strb}.
REQ-034 The FIFO SHALL be sub-module axil_cmd_fifo (synchronous, full/empty flags, DEPTH parameter).

Verification
REQ-035 Single push addr=0x10 data=0x5 strb=0xF -> o_wr pulse with the same fields, then after B handshake with resp=00: o_done=1, o_resp=00, o_err_cnt=0.
REQ-036 Push 5 commands with B stalled and DEPTH=4 -> s_cmd_ready=0 after the 4th accepted; the 5th is accepted after the first completion; issue order matches push order.
REQ-037 B response 2'b10 on 3 commands -> o_err_cnt=3; 300 error completions -> o_err_cnt=255.
REQ-038 Assert i_resetn low during WAIT_RESP with 3 queued -> o_wr=0, o_busy=0, no o_done, and s_cmd_ready=1 after release.
REQ-039 With AXIL_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, no B handshake -> o_timeout and o_done pulse 8 cycles after WAIT_RESP entry, o_resp=10; a stray bvalid while IDLE causes no o_done.
